// File: rtl/atm_pkg.sv
// Shared types for the cash dispenser: denomination codes and values, FSM states, note counts.
package atm_pkg;

  typedef logic [7:0] count_t;
  typedef logic [9:0] amt_t;

  typedef enum logic [1:0] {
    D50 = 2'd0,
    D20 = 2'd1,
    D10 = 2'd2,
    D5  = 2'd3
  } denom_t;

  typedef enum logic [2:0] {
    IDLE,
    PLAN,
    DISPENSE,
    DONE,
    REJECT
  } state_t;

  function automatic amt_t denom_value(input denom_t d);
    case (d)
      D50:     return 10'd50;
      D20:     return 10'd20;
      D10:     return 10'd10;
      default: return 10'd5;
    endcase
  endfunction

endpackage

// File: rtl/atm_denom_step.sv
// One greedy planning step: notes taken of one denomination and the amount still owed.
// Purely combinational; the caller sequences it one denomination per cycle.
module atm_denom_step
  import atm_pkg::*;
(
  input  amt_t   rem,
  input  amt_t   denom_val,
  input  count_t count,
  output count_t take,
  output amt_t   new_rem
);

  amt_t quot;

  always_comb begin
    quot    = rem / denom_val;
    take    = (quot > amt_t'(count)) ? count : quot[7:0];
    new_rem = rem - amt_t'(take) * denom_val;
  end

endmodule

// File: rtl/atm_cash_dispenser.sv
// Greedy ATM note dispenser: 4-cycle plan, then one note per motor ack, highest denomination first.
// Requests are taken only when idle with no refill; a note stays presented until the motor acks it.
module atm_cash_dispenser
  import atm_pkg::*;
#(
  parameter count_t INIT_COUNT = 8'd20,
  parameter count_t REFILL_MAX = 8'd255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [9:0]  req_amount,
  output logic        req_ready,
  input  logic        refill,
  input  logic [1:0]  refill_sel,
  input  logic [7:0]  refill_count,
  output logic        note_valid,
  output logic [1:0]  note_denom,
  input  logic        note_ack,
  output logic        done,
  output logic        rejected,
  output logic [31:0] inventory
);

  state_t     state_q, state_d;
  amt_t       rem_q, rem_d;
  logic [1:0] idx_q, idx_d;
  count_t     plan_q [4];
  count_t     plan_d [4];
  count_t     cnt_q  [4];
  count_t     cnt_d  [4];

  amt_t       step_val;
  count_t     step_take;
  amt_t       step_rem;
  logic [1:0] cur;
  logic [9:0] total;
  logic [8:0] refill_sum;
  count_t     refill_sat;

  assign step_val = denom_value(denom_t'(idx_q));

  atm_denom_step u_step (
    .rem       (rem_q),
    .denom_val (step_val),
    .count     (cnt_q[idx_q]),
    .take      (step_take),
    .new_rem   (step_rem)
  );

  // Lowest code with notes left is the largest denomination still owed.
  always_comb begin
    cur   = 2'd3;
    total = '0;
    for (int i = 3; i >= 0; i--) begin
      if (plan_q[i] != '0) cur = 2'(i);
    end
    for (int i = 0; i < 4; i++) begin
      total = total + 10'(plan_q[i]);
    end
  end

  always_comb begin
    refill_sum = {1'b0, cnt_q[refill_sel]} + {1'b0, refill_count};
    refill_sat = (refill_sum > {1'b0, REFILL_MAX}) ? REFILL_MAX : refill_sum[7:0];
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    plan_d     = plan_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    note_valid = 1'b0;
    note_denom = 2'd0;
    done       = 1'b0;
    rejected   = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = !refill;
        if (refill) begin
          cnt_d[refill_sel] = refill_sat;
        end else if (req_valid) begin
          rem_d   = req_amount;
          idx_d   = 2'd0;
          for (int i = 0; i < 4; i++) plan_d[i] = '0;
          state_d = PLAN;
        end
      end
      PLAN: begin
        plan_d[idx_q] = step_take;
        rem_d         = step_rem;
        idx_d         = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          if (step_rem != '0)
            state_d = REJECT;
          else if ((plan_q[0] | plan_q[1] | plan_q[2] | step_take) == '0)
            state_d = DONE;
          else
            state_d = DISPENSE;
        end
      end
      DISPENSE: begin
        note_valid = 1'b1;
        note_denom = cur;
        if (note_ack) begin
          plan_d[cur] = plan_q[cur] - 8'd1;
          cnt_d[cur]  = cnt_q[cur] - 8'd1;
          if (total == 10'd1) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      REJECT: begin
        rejected = 1'b1;
        rem_d    = '0;
        for (int i = 0; i < 4; i++) plan_d[i] = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        plan_q[i] <= '0;
        cnt_q[i]  <= INIT_COUNT;
      end
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      plan_q  <= plan_d;
      cnt_q   <= cnt_d;
    end
  end

  assign inventory = {cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3]};

endmodule

// File: doc/atm_cash_dispenser.md
ATM_CASH_DISPENSER -- requirements
Module: atm_cash_dispenser

Interface
REQ-001 SHALL have parameter INIT_COUNT, default 8'd20, giving the note count loaded into every cassette at reset.
REQ-002 SHALL have parameter REFILL_MAX, default 8'd255, giving the cassette saturation limit.
REQ-003 SHALL have port: clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: req_valid  input  1  withdrawal request present.
REQ-006 SHALL have port: req_amount  input  10  requested cash amount.
REQ-007 SHALL have port: req_ready  output  1  dispenser accepts a request this cycle.
REQ-008 SHALL have port: refill  input  1  cassette refill strobe.
REQ-009 SHALL have port: refill_sel  input  2  cassette selected for refill (0=50, 1=20, 2=10, 3=5).
REQ-010 SHALL have port: refill_count  input  8  notes added to the selected cassette.
REQ-011 SHALL have port: note_valid  output  1  one note presented to the motor.
REQ-012 SHALL have port: note_denom  output  2  denomination code of the presented note.
REQ-013 SHALL have port: note_ack  input  1  motor has taken the presented note.
REQ-014 SHALL have port: done  output  1  one-cycle pulse when a dispense completes.
REQ-015 SHALL have port: rejected  output  1  one-cycle pulse when a request cannot be paid.
REQ-016 SHALL have port: inventory  output  32  cassette counts, {c50,c20,c10,c5}, 8 bits each.

Function
REQ-017 SHALL implement states IDLE, PLAN, DISPENSE, DONE, REJECT.
REQ-018 In IDLE, req_ready SHALL be 1 when refill=0; in all other states it SHALL be 0.
REQ-019 A request SHALL be accepted on req_valid&&req_ready; req_amount is latched into rem, and the state goes to PLAN.
REQ-020 PLAN SHALL take exactly 4 cycles, one denomination per cycle in order 50,20,10,5: take=min(rem/d, cassette_count); planned[d]=take; rem-=take*d.
REQ-021 After PLAN, rem==0 SHALL go to DISPENSE; rem!=0 SHALL go to REJECT.
REQ-022 Planning SHALL be greedy only; a request payable only by a non-greedy mix SHALL be rejected.
REQ-023 For a request accepted at cycle T, rejected SHALL pulse at T+5 and the first note_valid SHALL rise at T+5.
REQ-024 DISPENSE SHALL present notes from the highest denomination first; note_valid and note_denom SHALL remain stable until note_ack.
REQ-025 On note_valid&&note_ack, the matching planned count and cassette count SHALL each decrement by 1.
REQ-026 The next note SHALL be presented in the following cycle; there are no bubbles beyond one cycle.
REQ-027 note_ack while note_valid=0 SHALL be ignored.
REQ-028 When the last note is acked, the state SHALL go to DONE; done SHALL pulse for one cycle, then the state returns to IDLE.
REQ-029 req_amount=0 SHALL pass through PLAN to DONE with no notes dispensed.
REQ-030 REJECT SHALL pulse rejected for one cycle, return to IDLE and leave inventory unchanged.
REQ-031 Refill SHALL apply only in IDLE: count = min(count+refill_count, REFILL_MAX).
REQ-032 Refill in any other state SHALL be ignored.
REQ-033 inventory SHALL reflect the registered counts, updated the cycle after each ack or refill.

Reset
REQ-034 Asserting reset_n=0 SHALL immediately force IDLE, note_valid=0, done=0, rejected=0, note_denom=0, rem=0, planned counts=0 and all cassettes=INIT_COUNT.
REQ-035 Reset SHALL apply at any point, including mid-DISPENSE; notes not yet acked SHALL be abandoned.
REQ-036 req_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-037 Shared package atm_pkg SHALL hold the denomination codes, the denomination values (50,20,10,5), the state enum and the 8-bit count type.
REQ-038 The per-denomination take/remainder arithmetic SHALL be the combinational sub-module atm_denom_step (rem, denom value, count -> take, new rem); the top instantiates it once and sequences it through PLAN.
REQ-039 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-040 Bench SHALL cover: reset, req 185 -> notes 50,50,50,20,10,5; done pulses; inventory {17,19,19,19}.
REQ-041 Bench SHALL cover: req 7 -> rejected at T+5; no note_valid; inventory unchanged.
REQ-042 Bench SHALL cover: c10=0, c5=0, req 60 -> greedy takes one 50, rem 10 -> rejected.
REQ-043 Bench SHALL cover: note_ack held low 3 cycles on the first note -> note_valid and note_denom stable; counts unchanged until ack.
REQ-044 Bench SHALL cover: refill sel=3 count=250 from 20 -> saturates at 255; refill during DISPENSE -> ignored; refill and req_valid together in IDLE -> refill applied, request not accepted.
REQ-045 Bench SHALL cover: reset_n low mid-DISPENSE of 100 -> note_valid drops immediately; inventory returns to INIT_COUNT.
